// File: rtl/ct_f_spsram_arb.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_arb
//
// Purpose:
//   Front end for one single-port SRAM macro. After reset it zero-fills
//   every word of the array, one word per cycle. It then shares the macro
//   between two valid/ready requesters. Arbitration is round-robin. The
//   macro takes at most one access per cycle. Read data comes back on the
//   cycle after the access.
//
// Ports:
//   CLK, RST             clock; synchronous active-high reset
//   reqN_vld / reqN_rdy  command handshake for requester N (N = 0, 1)
//   reqN_wr              1 = write, 0 = read
//   reqN_addr            word address
//   reqN_wdata           write data
//   reqN_wmask           per-bit write mask, active-high
//   rspN_vld / rspN_data read response for requester N (one cycle pulse)
//   init_done            array is zero-filled and arbitration is running
//   A, CEN, GWEN, WEN, D macro control and write pins (control is active-low)
//   Q                    macro read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module ct_f_spsram_arb #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 144,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,

   input  logic                  req0_vld,
   output logic                  req0_rdy,
   input  logic                  req0_wr,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic [DATA_WIDTH-1:0] req0_wmask,
   output logic                  rsp0_vld,
   output logic [DATA_WIDTH-1:0] rsp0_data,

   input  logic                  req1_vld,
   output logic                  req1_rdy,
   input  logic                  req1_wr,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   input  logic [DATA_WIDTH-1:0] req1_wmask,
   output logic                  rsp1_vld,
   output logic [DATA_WIDTH-1:0] rsp1_data,

   output logic                  init_done,

   output logic [ADDR_WIDTH-1:0] A,
   output logic                  CEN,
   output logic                  GWEN,
   output logic [DATA_WIDTH-1:0] WEN,
   output logic [DATA_WIDTH-1:0] D,
   input  logic [DATA_WIDTH-1:0] Q
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Index of the last word. The counter has one spare bit so that it
   // parks at 2^ADDR_WIDTH rather than wrapping back to word 0.
   localparam logic [ADDR_WIDTH:0]   LAST_ADDR   = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] ALL_ONES    = {DATA_WIDTH{1'b1}};
   localparam logic [DATA_WIDTH-1:0] ALL_ZEROS   = {DATA_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO   = {ADDR_WIDTH{1'b0}};
   localparam state_t                STATE_RST   = INIT_EN ? ST_INIT : ST_RUN;
   localparam logic                  DONE_RST    = ~INIT_EN;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
   logic                  rr_ptr_q, rr_ptr_d;
   logic                  rsp0_vld_q, rsp0_vld_d;
   logic                  rsp1_vld_q, rsp1_vld_d;
   logic                  init_done_q, init_done_d;

   logic                  run;
   logic                  grant0;
   logic                  grant1;

   // Arbitration. Each grant can happen only in RUN and outside reset.
   // A lone valid requester always wins. When both are valid, rr_ptr
   // picks the winner.
   always_comb begin
      run    = (state_q == ST_RUN) & ~RST;
      grant0 = run & req0_vld & (~req1_vld | ~rr_ptr_q);
      grant1 = run & req1_vld & (~req0_vld |  rr_ptr_q);
   end

   // Next-state logic for the sequencer, round-robin pointer and response flags
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      init_done_d = init_done_q;
      rsp0_vld_d  = 1'b0;
      rsp1_vld_d  = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + CNT_ONE;
            if (init_cnt_q == LAST_ADDR) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end else begin
               state_d     = ST_INIT;
               init_done_d = 1'b0;
            end
         end
         ST_RUN: begin
            // The winner goes to the back of the line. With no grant the
            // pointer keeps its value.
            if (grant0) begin
               rr_ptr_d = 1'b1;
            end else if (grant1) begin
               rr_ptr_d = 1'b0;
            end else begin
               rr_ptr_d = rr_ptr_q;
            end
            rsp0_vld_d = grant0 & ~req0_wr;
            rsp1_vld_d = grant1 & ~req1_wr;
         end
         default: begin
            state_d    = STATE_RST;
            init_cnt_d = {(ADDR_WIDTH+1){1'b0}};
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= STATE_RST;
         init_cnt_q  <= {(ADDR_WIDTH+1){1'b0}};
         rr_ptr_q    <= 1'b0;
         rsp0_vld_q  <= 1'b0;
         rsp1_vld_q  <= 1'b0;
         init_done_q <= DONE_RST;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp0_vld_q  <= rsp0_vld_d;
         rsp1_vld_q  <= rsp1_vld_d;
         init_done_q <= init_done_d;
      end
   end

   // SRAM pin drive. The macro stays idle during reset. In INIT the
   // sequencer owns the pins. In RUN the granted requester owns them.
   always_comb begin
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = ALL_ONES;
      A    = ADDR_ZERO;
      D    = ALL_ZEROS;
      if (RST) begin
         CEN = 1'b1;
      end else if (state_q == ST_INIT) begin
         CEN  = 1'b0;
         GWEN = 1'b0;
         WEN  = ALL_ZEROS;
         A    = init_cnt_q[ADDR_WIDTH-1:0];
         D    = ALL_ZEROS;
      end else if (grant0) begin
         CEN = 1'b0;
         A   = req0_addr;
         if (req0_wr) begin
            GWEN = 1'b0;
            WEN  = ~req0_wmask;
            D    = req0_wdata;
         end else begin
            GWEN = 1'b1;
         end
      end else if (grant1) begin
         CEN = 1'b0;
         A   = req1_addr;
         if (req1_wr) begin
            GWEN = 1'b0;
            WEN  = ~req1_wmask;
            D    = req1_wdata;
         end else begin
            GWEN = 1'b1;
         end
      end else begin
         CEN = 1'b1;
      end
   end

   // Handshake and response outputs. A response already in flight is
   // masked as soon as reset is asserted.
   always_comb begin
      req0_rdy  = grant0;
      req1_rdy  = grant1;
      rsp0_vld  = rsp0_vld_q & ~RST;
      rsp1_vld  = rsp1_vld_q & ~RST;
      rsp0_data = Q;
      rsp1_data = Q;
      init_done = init_done_q;
   end

endmodule

// File: tb/tb_ct_f_spsram_arb.sv
module tb_ct_f_spsram_arb;
   localparam int AW    = 10;
   localparam int DW    = 144;
   localparam int DEPTH = 1 << AW;

   logic          CLK = 1'b0;
   logic          RST;
   logic          req0_vld, req0_rdy, req0_wr, rsp0_vld;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, req0_wmask, rsp0_data;
   logic          req1_vld, req1_rdy, req1_wr, rsp1_vld;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, req1_wmask, rsp1_data;
   logic          init_done;
   logic [AW-1:0] A;
   logic          CEN, GWEN;
   logic [DW-1:0] WEN, D, Q;

   logic [DW-1:0] sram [DEPTH];

   always #5 CLK = ~CLK;

   ct_f_spsram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST),
      .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_wr(req0_wr),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
      .rsp0_vld(rsp0_vld), .rsp0_data(rsp0_data),
      .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_wr(req1_wr),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
      .rsp1_vld(rsp1_vld), .rsp1_data(rsp1_data),
      .init_done(init_done),
      .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
   );

   // Behavioural single-port SRAM: bit-masked write, registered read.
   always @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
         else       Q <= sram[A];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference model: expected array contents, arbitration pointer, init progress, pending responses
   logic [DW-1:0] exp_mem [DEPTH];
   bit            m_known = 1'b0;
   bit            m_init, m_done, m_rr;
   int            m_cnt;
   bit            m_rv [2];
   logic [DW-1:0] m_rd [2];
   bit            pend [2];

   // Observations captured at each sample point for directed checks
   logic          obs_rdy0, obs_rsp0_vld, obs_rsp1_vld, obs_done, obs_cen;
   logic [DW-1:0] obs_rsp0_data, obs_wen;
   logic [AW-1:0] obs_a;

   function automatic logic [DW-1:0] rand_word();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[DW-1:0];
   endfunction

   // One cycle: sample at negedge+1, compare with the model, advance the model, move to the next negedge.
   task automatic tick();
      bit            v [2];
      bit            w [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] wd [2];
      logic [DW-1:0] wm [2];
      int            g;
      v[0] = req0_vld; w[0] = req0_wr; ad[0] = req0_addr; wd[0] = req0_wdata; wm[0] = req0_wmask;
      v[1] = req1_vld; w[1] = req1_wr; ad[1] = req1_addr; wd[1] = req1_wdata; wm[1] = req1_wmask;
      #1;
      obs_rdy0 = req0_rdy; obs_rsp0_vld = rsp0_vld; obs_rsp1_vld = rsp1_vld;
      obs_rsp0_data = rsp0_data; obs_wen = WEN; obs_a = A; obs_done = init_done; obs_cen = CEN;
      if (m_known) chk("init_done", init_done, m_done);
      chk("rsp0_vld", rsp0_vld, (!RST && m_known) ? m_rv[0] : 1'b0);
      chk("rsp1_vld", rsp1_vld, (!RST && m_known) ? m_rv[1] : 1'b0);
      if (!RST && m_known && m_rv[0]) chk("rsp0_data", rsp0_data, m_rd[0]);
      if (!RST && m_known && m_rv[1]) chk("rsp1_data", rsp1_data, m_rd[1]);
      g = -1;
      if (RST) begin
         chk("rst_cen", CEN, 1'b1);
         chk("rst_gwen", GWEN, 1'b1);
         chk("rst_wen", WEN, {DW{1'b1}});
         chk("rst_rdy0", req0_rdy, 1'b0);
         chk("rst_rdy1", req1_rdy, 1'b0);
         m_init = 1'b1; m_cnt = 0; m_rr = 1'b0; m_done = 1'b0; m_known = 1'b1;
         m_rv[0] = 1'b0; m_rv[1] = 1'b0;
         pend[0] = v[0]; pend[1] = v[1];
      end else if (m_init) begin
         chk("init_cen", CEN, 1'b0);
         chk("init_gwen", GWEN, 1'b0);
         chk("init_wen", WEN, {DW{1'b0}});
         chk("init_d", D, {DW{1'b0}});
         chk("init_a", A, m_cnt[AW-1:0]);
         chk("init_rdy0", req0_rdy, 1'b0);
         chk("init_rdy1", req1_rdy, 1'b0);
         exp_mem[m_cnt] = {DW{1'b0}};
         m_rv[0] = 1'b0; m_rv[1] = 1'b0;
         if (m_cnt == DEPTH - 1) begin
            m_init = 1'b0;
            m_done = 1'b1;
         end
         m_cnt++;
         pend[0] = v[0]; pend[1] = v[1];
      end else begin
         if (v[0] && v[1]) g = m_rr ? 1 : 0;
         else if (v[0])    g = 0;
         else if (v[1])    g = 1;
         chk("rdy0", req0_rdy, g == 0);
         chk("rdy1", req1_rdy, g == 1);
         m_rv[0] = 1'b0; m_rv[1] = 1'b0;
         if (g < 0) begin
            chk("idle_cen", CEN, 1'b1);
            chk("idle_gwen", GWEN, 1'b1);
            chk("idle_wen", WEN, {DW{1'b1}});
            chk("idle_a", A, {AW{1'b0}});
            chk("idle_d", D, {DW{1'b0}});
         end else begin
            chk("acc_cen", CEN, 1'b0);
            chk("acc_a", A, ad[g]);
            if (w[g]) begin
               chk("wr_gwen", GWEN, 1'b0);
               chk("wr_wen", WEN, ~wm[g]);
               chk("wr_d", D, wd[g]);
               exp_mem[ad[g]] = (exp_mem[ad[g]] & ~wm[g]) | (wd[g] & wm[g]);
            end else begin
               chk("rd_gwen", GWEN, 1'b1);
               chk("rd_wen", WEN, {DW{1'b1}});
               chk("rd_d", D, {DW{1'b0}});
               m_rv[g] = 1'b1;
               m_rd[g] = exp_mem[ad[g]];
            end
            m_rr = (g == 0);
         end
         pend[0] = v[0] && (g != 0);
         pend[1] = v[1] && (g != 1);
      end
      @(negedge CLK);
   endtask

   task automatic set_req(input int i, input bit v, input bit w, input int a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
      if (i == 0) begin
         req0_vld = v; req0_wr = w; req0_addr = a[AW-1:0]; req0_wdata = d; req0_wmask = m;
      end else begin
         req1_vld = v; req1_wr = w; req1_addr = a[AW-1:0]; req1_wdata = d; req1_wmask = m;
      end
   endtask

   task automatic rand_req(input int i);
      logic [DW-1:0] m;
      int            sel;
      sel = $urandom_range(0, 3);
      case (sel)
         0:       m = {DW{1'b1}};
         1:       m = {DW{1'b0}};
         2:       m = {{(DW-8){1'b0}}, 8'hFF};
         default: m = rand_word();
      endcase
      set_req(i, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15), rand_word(), m);
   endtask

   task automatic idle();
      set_req(0, 1'b0, 1'b0, 0, {DW{1'b0}}, {DW{1'b0}});
      set_req(1, 1'b0, 1'b0, 0, {DW{1'b0}}, {DW{1'b0}});
   endtask

   task automatic rand_phase(input int n);
      for (int k = 0; k < n; k++) begin
         if (!pend[0]) rand_req(0);
         if (!pend[1]) rand_req(1);
         tick();
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) sram[i] = rand_word();
   end

   initial begin
      RST = 1'b1;
      idle();
      @(negedge CLK);
      repeat (3) tick();

      // Zero-fill with both requesters already waiting on reads
      RST = 1'b0;
      set_req(0, 1'b1, 1'b0, 1, {DW{1'b0}}, {DW{1'b0}});
      set_req(1, 1'b1, 1'b0, 2, {DW{1'b0}}, {DW{1'b0}});
      repeat (DEPTH) tick();

      // Both held valid: grants alternate 0,1,0,1 from rr_ptr = 0
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_alt", obs_rdy0, (k % 2) == 0);
      end
      chk("init_done_up", obs_done, 1'b1);
      idle();

      // Write 0xABCD to addr 5, read it back the next cycle
      set_req(0, 1'b1, 1'b1, 5, 144'hABCD, {DW{1'b1}});
      tick();
      set_req(0, 1'b1, 1'b0, 5, {DW{1'b0}}, {DW{1'b0}});
      tick();
      idle();
      tick();
      chk("raw_vld", obs_rsp0_vld, 1'b1);
      chk("raw_data", obs_rsp0_data, 144'hABCD);
      chk("raw_rsp1", obs_rsp1_vld, 1'b0);

      // Partial mask: only the low byte of an all-ones word lands
      set_req(0, 1'b1, 1'b1, 7, {DW{1'b1}}, 144'hFF);
      tick();
      chk("mask_wen", obs_wen, ~(144'hFF));
      set_req(0, 1'b1, 1'b0, 7, {DW{1'b0}}, {DW{1'b0}});
      tick();
      idle();
      tick();
      chk("mask_data", obs_rsp0_data, 144'hFF);

      rand_phase(3000);

      // Reset at INIT cycle 500 restarts the fill from word 0
      RST = 1'b1;
      tick();
      RST = 1'b0;
      repeat (500) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick();
      chk("restart_a", obs_a, {AW{1'b0}});
      repeat (DEPTH - 1) tick();
      chk("restart_not_done", obs_done, 1'b0);
      tick();
      chk("restart_done", obs_done, 1'b1);

      // Read granted to req1, reset the next cycle: response is dropped
      set_req(1, 1'b1, 1'b0, 3, {DW{1'b0}}, {DW{1'b0}});
      tick();
      idle();
      RST = 1'b1;
      tick();
      chk("rst_drop_rsp1", obs_rsp1_vld, 1'b0);
      RST = 1'b0;
      tick();
      chk("reinit_cen", obs_cen, 1'b0);
      chk("reinit_a", obs_a, {AW{1'b0}});
      repeat (DEPTH - 1) tick();
      rand_phase(500);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
